// File: rtl/dma_periph_pkg.sv
// Shared types and helpers for the DMA peripheral responder.
// One-hot FSM encoding with bit-index constants, plus transfer direction codes.
package dma_periph_pkg;

  localparam int IDLE_IDX = 0;
  localparam int REQ_IDX  = 1;
  localparam int XFER_IDX = 2;
  localparam int DONE_IDX = 3;

  typedef enum logic [3:0] {
    IDLE = 4'b0001,
    REQ  = 4'b0010,
    XFER = 4'b0100,
    DONE = 4'b1000
  } state_t;

  localparam logic DIR_DEV2MEM = 1'b1;
  localparam logic DIR_MEM2DEV = 1'b0;

  // Device-to-memory needs data to send; memory-to-device needs room to receive.
  function automatic logic reqCond(input logic d, input int cnt, input int depth,
                                   input int thresh);
    return (d == DIR_DEV2MEM) ? (cnt >= thresh) : ((depth - cnt) >= thresh);
  endfunction

endpackage

// File: rtl/dma_sync_fifo.sv
// Synchronous first-word-through FIFO; push and pop may coincide, flush beats both.
module dma_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rstN,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             pushOk;
  logic             popOk;

  assign full   = (count == (AW+1)'(DEPTH));
  assign empty  = (count == '0);
  assign pushOk = push && !full && !flush;
  assign popOk  = pop && !empty && !flush;
  assign head   = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (pushOk) mem[wrPtr] <= pushData;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (pushOk) wrPtr <= wrPtr + AW'(1);
      if (popOk)  rdPtr <= rdPtr + AW'(1);
      count <= count + (AW+1)'(pushOk) - (AW+1)'(popOk);
    end
  end

endmodule

// File: rtl/dma_periph_responder.sv
// Device-side responder to 8237A-style DMA cycles: DREQ from FIFO level,
// sources DB on IOR_N, sinks DB on IOW_N, terminates on EOP_N.
//   state | meaning
//   IDLE  | no request; dir latched while enable is high
//   REQ   | DREQ high, waiting for DACK
//   XFER  | DACK granted, waiting for strobe rising edge
//   DONE  | terminated by EOP_N; held until enable drops
module dma_periph_responder
  import dma_periph_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int THRESH = 1
) (
  input  logic                   CLK,
  input  logic                   RESET_N,
  output logic                   DREQ,
  input  logic                   DACK,
  input  logic                   IOR_N,
  input  logic                   IOW_N,
  input  logic                   EOP_N,
  inout  wire  [7:0]             DB,
  input  logic                   enable,
  input  logic                   dir,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [7:0]             out_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   done,
  output logic                   err
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_t          stateQ, stateD;
  logic            dreqQ, doneQ, errQ, eopSeenQ, dirQ, iorQ, iowQ;
  logic [7:0]      holdQ;
  logic [7:0]      head;
  logic            fifoFull, fifoEmpty;
  logic            inIdle, inXfer, inDone;
  logic            rdEdge, wrEdge, busPop, busPush, localPush, localPop;
  logic            fifoPush, fifoPop, fifoFlush;
  logic [7:0]      pushData;
  logic [CW-1:0]   countAfter;
  logic            effDir, cond, eopNow, wrongDir, completeErr, holdCapture, dbDrive;

  assign inIdle = stateQ[IDLE_IDX];
  assign inXfer = stateQ[XFER_IDX];
  assign inDone = stateQ[DONE_IDX];

  // Completion is the strobe returning high while DACK is still asserted.
  assign rdEdge = DACK && (dirQ == DIR_DEV2MEM) && !iorQ && IOR_N;
  assign wrEdge = DACK && (dirQ == DIR_MEM2DEV) && !iowQ && IOW_N;

  assign busPop      = inXfer && rdEdge && !fifoEmpty;
  assign busPush     = inXfer && wrEdge && !fifoFull;
  assign in_ready    = (dirQ == DIR_DEV2MEM) && !fifoFull;
  assign out_valid   = (dirQ == DIR_MEM2DEV) && !fifoEmpty;
  assign localPush   = in_valid && in_ready;
  assign localPop    = out_valid && out_ready;
  assign fifoPush    = localPush || busPush;
  assign fifoPop     = localPop || busPop;
  assign fifoFlush   = flush && (inIdle || inDone);
  assign pushData    = (dirQ == DIR_DEV2MEM) ? in_data : holdQ;
  assign countAfter  = fifoFlush ? '0 : (count + CW'(fifoPush) - CW'(fifoPop));

  assign effDir      = (inIdle && enable) ? dir : dirQ;
  assign cond        = reqCond(effDir, int'(countAfter), DEPTH, THRESH);
  assign eopNow      = eopSeenQ || !EOP_N;
  assign wrongDir    = DACK && (((dirQ == DIR_DEV2MEM) && !IOW_N) ||
                                ((dirQ == DIR_MEM2DEV) && !IOR_N));
  assign completeErr = (rdEdge && fifoEmpty) || (wrEdge && fifoFull);
  assign holdCapture = DACK && (dirQ == DIR_MEM2DEV) && !IOW_N;

  assign dbDrive  = DACK && !IOR_N && (dirQ == DIR_DEV2MEM);
  assign DB       = dbDrive ? (fifoEmpty ? 8'hFF : head) : 8'hzz;
  assign out_data = head;
  assign DREQ     = dreqQ;
  assign done     = doneQ;
  assign err      = errQ;

  dma_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) uFifo (
    .clk      (CLK),
    .rstN     (RESET_N),
    .push     (fifoPush),
    .pushData (pushData),
    .pop      (fifoPop),
    .flush    (fifoFlush),
    .head     (head),
    .count    (count),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      IDLE: if (enable && cond) stateD = REQ;
      REQ: begin
        if (!enable)   stateD = IDLE;
        else if (DACK) stateD = XFER;
      end
      XFER: begin
        if (rdEdge || wrEdge) begin
          if (eopNow)              stateD = DONE;
          else if (enable && cond) stateD = REQ;
          else                     stateD = IDLE;
        end else if (!DACK || !enable) begin
          stateD = (enable && cond) ? REQ : IDLE;
        end
      end
      DONE: if (!enable) stateD = IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      stateQ   <= IDLE;
      dreqQ    <= 1'b0;
      doneQ    <= 1'b0;
      errQ     <= 1'b0;
      eopSeenQ <= 1'b0;
      dirQ     <= DIR_MEM2DEV;
      iorQ     <= 1'b1;
      iowQ     <= 1'b1;
      holdQ    <= '0;
    end else begin
      stateQ   <= stateD;
      dreqQ    <= (stateD == REQ) || (stateD == XFER);
      iorQ     <= IOR_N;
      iowQ     <= IOW_N;
      eopSeenQ <= (stateD == XFER) && (eopSeenQ || (inXfer && !EOP_N));
      if (inIdle && enable) dirQ <= dir;
      if (holdCapture) holdQ <= DB;
      if ((stateD == DONE) && !inDone)      doneQ <= 1'b1;
      else if (inDone && (stateD == IDLE))  doneQ <= 1'b0;
      if (wrongDir || completeErr) errQ <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dma_periph_responder.sv
// Scoreboard bench: expected bus reads and local pops are queued by the stimulus
// and consumed by a negedge monitor; status flags are checked directly.
module tb_dma_periph_responder;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic       DREQ, DACK, IOR_N, IOW_N, EOP_N;
  wire  [7:0] DB;
  logic [7:0] tbDb;
  logic       tbDbEn;
  logic       enable, dir, flush;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] in_data, out_data;
  logic [3:0] count;
  logic       done, err;

  int checks = 0;
  int failures = 0;
  logic [7:0] rdQ[$];
  logic [7:0] outQ[$];

  assign DB = tbDbEn ? tbDb : 8'hzz;

  always #5 CLK = ~CLK;

  dma_periph_responder #(.DEPTH(8), .THRESH(1)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .DACK(DACK), .IOR_N(IOR_N),
    .IOW_N(IOW_N), .EOP_N(EOP_N), .DB(DB), .enable(enable), .dir(dir),
    .flush(flush), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .done(done), .err(err)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rdPulse(input logic eopOnSecond);
    DACK = 1'b1;
    step();
    IOR_N = 1'b0;
    step();
    if (eopOnSecond) EOP_N = 1'b0;
    step();
    IOR_N = 1'b1;
    EOP_N = 1'b1;
    step();
    DACK = 1'b0;
  endtask

  task automatic wrPulse(input logic [7:0] d, input int lowCycles, input logic popAtDone);
    DACK = 1'b1;
    step();
    IOW_N = 1'b0;
    tbDb = d;
    tbDbEn = 1'b1;
    repeat (lowCycles) step();
    IOW_N = 1'b1;
    tbDbEn = 1'b0;
    out_ready = popAtDone;
    step();
    out_ready = 1'b0;
    DACK = 1'b0;
  endtask

  // Monitor: first low cycle of each IOR_N pulse under DACK, and every local pop.
  initial begin
    logic prevIorN = 1'b1;
    forever begin
      @(negedge CLK);
      if (RESET_N && DACK && !IOR_N && prevIorN) begin
        if (rdQ.size() == 0) chk("unexpected_bus_read", 32'(DB), 32'hFFFF_FFFF);
        else chk("bus_read_DB", 32'(DB), 32'(rdQ.pop_front()));
      end
      if (RESET_N && out_valid && out_ready) begin
        if (outQ.size() == 0) chk("unexpected_pop", 32'(out_data), 32'hFFFF_FFFF);
        else chk("local_pop_data", 32'(out_data), 32'(outQ.pop_front()));
      end
      prevIorN = IOR_N;
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    RESET_N = 1'b0; DACK = 1'b0; IOR_N = 1'b1; IOW_N = 1'b1; EOP_N = 1'b1;
    tbDb = 8'h00; tbDbEn = 1'b0; enable = 1'b0; dir = 1'b0; flush = 1'b0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    repeat (3) step();
    RESET_N = 1'b1;
    step();
    chk("rst_DREQ", 32'(DREQ), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);

    // device-to-memory: two bus reads
    dir = 1'b1; enable = 1'b1;
    step();
    chk("d2m_idle_DREQ", 32'(DREQ), 0);
    chk("d2m_in_ready", 32'(in_ready), 1);
    in_valid = 1'b1; in_data = 8'hA5;
    step();
    in_data = 8'h3C;
    step();
    in_valid = 1'b0;
    chk("d2m_count2", 32'(count), 2);
    chk("d2m_DREQ_up", 32'(DREQ), 1);
    rdQ.push_back(8'hA5);
    rdQ.push_back(8'h3C);
    rdPulse(1'b0);
    chk("d2m_count1", 32'(count), 1);
    chk("d2m_DREQ_mid", 32'(DREQ), 1);
    rdPulse(1'b0);
    chk("d2m_count0", 32'(count), 0);
    chk("d2m_DREQ_fall", 32'(DREQ), 0);
    enable = 1'b0;
    step();

    // memory-to-device: 3-cycle IOW_N pulse, one push
    dir = 1'b0; enable = 1'b1;
    step();
    chk("m2d_DREQ_up", 32'(DREQ), 1);
    chk("m2d_in_ready", 32'(in_ready), 0);
    wrPulse(8'h5A, 3, 1'b0);
    chk("m2d_count1", 32'(count), 1);
    outQ.push_back(8'h5A);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("m2d_count0", 32'(count), 0);

    // local pop and bus push on the same edge
    wrPulse(8'h11, 2, 1'b0);
    chk("sim_pre_count", 32'(count), 1);
    outQ.push_back(8'h11);
    outQ.push_back(8'h22);
    wrPulse(8'h22, 2, 1'b1);
    chk("sim_count_same", 32'(count), 1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("sim_count_drain", 32'(count), 0);

    // abort: DACK drops with no strobe
    DACK = 1'b1;
    step();
    chk("abort_xfer_DREQ", 32'(DREQ), 1);
    DACK = 1'b0;
    step();
    chk("abort_DREQ", 32'(DREQ), 1);
    chk("abort_count", 32'(count), 0);
    chk("pre_err", 32'(err), 0);

    // EOP on second low cycle of a read pulse
    enable = 1'b0;
    step();
    dir = 1'b1; enable = 1'b1;
    step();
    in_valid = 1'b1; in_data = 8'h77;
    step();
    in_data = 8'h88;
    step();
    in_valid = 1'b0;
    rdQ.push_back(8'h77);
    rdPulse(1'b1);
    chk("eop_count", 32'(count), 1);
    chk("eop_done", 32'(done), 1);
    chk("eop_DREQ", 32'(DREQ), 0);
    repeat (2) step();
    chk("eop_hold_done", 32'(done), 1);
    chk("eop_hold_DREQ", 32'(DREQ), 0);
    enable = 1'b0;
    step();
    chk("eop_done_clear", 32'(done), 0);

    // flush wins over a simultaneous push
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h99;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_wins", 32'(count), 0);

    // fill, then write side with FIFO full
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 8'(i);
      step();
    end
    in_valid = 1'b0;
    chk("full_count", 32'(count), 8);
    chk("full_in_ready", 32'(in_ready), 0);
    dir = 1'b0; enable = 1'b1;
    step();
    chk("full_DREQ_a", 32'(DREQ), 0);
    step();
    chk("full_DREQ_b", 32'(DREQ), 0);
    DACK = 1'b1; IOW_N = 1'b0; tbDb = 8'hEE; tbDbEn = 1'b1;
    step();
    IOW_N = 1'b1; tbDbEn = 1'b0;
    step();
    DACK = 1'b0;
    chk("full_err", 32'(err), 1);
    chk("full_count_kept", 32'(count), 8);

    // asynchronous reset in the middle of a read
    enable = 1'b0;
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    dir = 1'b1; enable = 1'b1;
    step();
    in_valid = 1'b1; in_data = 8'hA1;
    step();
    in_valid = 1'b0;
    rdQ.push_back(8'hA1);
    DACK = 1'b1;
    step();
    IOR_N = 1'b0;
    @(negedge CLK);
    #2;
    RESET_N = 1'b0;
    tbDb = 8'h00;
    tbDbEn = 1'b1;
    #1;
    chk("arst_DB_released", 32'(DB), 0);
    chk("arst_DREQ", 32'(DREQ), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_err", 32'(err), 0);
    chk("arst_in_ready", 32'(in_ready), 0);
    DACK = 1'b0; IOR_N = 1'b1; tbDbEn = 1'b0; enable = 1'b0;
    #2;
    RESET_N = 1'b1;
    repeat (2) step();

    chk("rdQ_drained", 32'(rdQ.size()), 0);
    chk("outQ_drained", 32'(outQ.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
